// File: rtl/seq_pkg.sv
// Shared types and constants for the tone sequencer: state encoding, envelope
// unity and the default-width note table entry layout.
package seq_pkg;

    localparam logic [15:0] ENV_ONE   = 16'h4000;
    localparam int          FCW_W     = 30;
    localparam int          DUR_W_DEF = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } seq_state_t;

    typedef struct packed {
        logic [FCW_W-1:0]     fcw;
        logic [DUR_W_DEF-1:0] dur;
        logic                 last;
    } note_t;

endpackage

// File: rtl/seq_note_ram.sv
// Note table: one write port, one registered read port (1-cycle latency),
// written as an async-read array plus output register so it maps onto LUT RAM.
module seq_note_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 51,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a programmed note table, driving the ddfs frequency word and a
// linear attack/sustain/release envelope advanced once per accepted sample.
module tone_sequencer
    import seq_pkg::*;
#(
    parameter int N_NOTES  = 16,
    parameter int DUR_W    = 20,
    parameter int ENV_STEP = 64,
    parameter int ADDR_W   = $clog2(N_NOTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [29:0]       tbl_fcw,
    input  logic [DUR_W-1:0]  tbl_dur,
    input  logic              tbl_last,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              sample_tick,
    output logic [29:0]       fccw,
    output logic [15:0]       env,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int                RAMP_LEN = 16'h4000 / ENV_STEP;
    localparam logic [DUR_W-1:0]  RAMP_D   = DUR_W'(RAMP_LEN);
    localparam logic [15:0]       STEP     = 16'(ENV_STEP);
    localparam logic [ADDR_W-1:0] IDX_MAX  = ADDR_W'(N_NOTES - 1);

    // Entry layout follows note_t but with the configured duration width.
    typedef struct packed {
        logic [29:0]      fcw;
        logic [DUR_W-1:0] dur;
        logic             last;
    } entry_t;

    seq_state_t        state_q, state_d;
    logic              ld2_q, ld2_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              stop_q, stop_d;
    logic              last_q, last_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [15:0]       env_q, env_d;
    logic [29:0]       fccw_q, fccw_d;
    logic [ADDR_W-1:0] note_idx_q, note_idx_d;
    logic              done_q, done_d;

    entry_t            wr_entry, rd_entry;
    logic [15:0]       env_up, env_dn;
    logic [DUR_W-1:0]  rem_dec;
    logic              note_end, end_last, go_idle;

    assign wr_entry = '{fcw: tbl_fcw, dur: tbl_dur, last: tbl_last};

    seq_note_ram #(
        .DEPTH  (N_NOTES),
        .WIDTH  ($bits(entry_t)),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (tbl_we),
        .wr_addr (tbl_addr),
        .wr_data (wr_entry),
        .rd_addr (idx_q),
        .rd_data (rd_entry)
    );

    always_comb begin
        state_d    = state_q;
        ld2_d      = 1'b0;
        idx_d      = idx_q;
        stop_d     = stop_q;
        last_d     = last_q;
        rem_d      = rem_q;
        env_d      = env_q;
        fccw_d     = fccw_q;
        note_idx_d = note_idx_q;
        done_d     = 1'b0;
        note_end   = 1'b0;
        end_last   = last_q;
        go_idle    = 1'b0;

        env_up  = (env_q > ENV_ONE - STEP) ? ENV_ONE : env_q + STEP;
        env_dn  = (env_q < STEP) ? 16'h0 : env_q - STEP;
        rem_dec = (rem_q == '0) ? '0 : rem_q - 1'b1;

        if (stop && state_q != S_IDLE) stop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (!ld2_q) begin
                    ld2_d = 1'b1;
                end else if (rd_entry.dur == '0) begin
                    // Zero-length entry: fall straight through to next-index logic.
                    note_end = 1'b1;
                    end_last = rd_entry.last;
                end else begin
                    fccw_d     = rd_entry.fcw;
                    rem_d      = rd_entry.dur;
                    last_d     = rd_entry.last;
                    note_idx_d = idx_q;
                    state_d    = S_ATTACK;
                end
            end
            S_ATTACK, S_SUSTAIN: begin
                if (sample_tick) begin
                    rem_d = rem_dec;
                    if (state_q == S_ATTACK) begin
                        env_d = env_up;
                        if (env_up == ENV_ONE) state_d = S_SUSTAIN;
                    end
                    if (rem_dec <= RAMP_D) state_d = S_RELEASE;
                end
                if (stop || stop_q) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (sample_tick) begin
                    rem_d = rem_dec;
                    env_d = env_dn;
                    // A forced release ends on env alone; otherwise both must run out.
                    if (env_dn == 16'h0 && (rem_dec == '0 || stop_q)) note_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (note_end) begin
            if (stop_q) begin
                go_idle = 1'b1;
            end else if (end_last || idx_q == IDX_MAX) begin
                if (loop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else begin
                    go_idle = 1'b1;
                end
            end else begin
                state_d = S_LOAD;
                idx_d   = idx_q + 1'b1;
            end
        end

        if (go_idle) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ld2_q      <= 1'b0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            last_q     <= 1'b0;
            rem_q      <= '0;
            env_q      <= 16'h0;
            fccw_q     <= '0;
            note_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld2_q      <= ld2_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            env_q      <= env_d;
            fccw_q     <= fccw_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
        end
    end

    assign fccw     = fccw_q;
    assign env      = env_q;
    assign busy     = (state_q != S_IDLE);
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: envelope shape, looping, short notes,
// stop/restart, zero-duration skip and reset behaviour.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [29:0] tbl_fcw;
    logic [19:0] tbl_dur;
    logic        tbl_last;
    logic        start, stop, loop, sample_tick;
    logic [29:0] fccw;
    logic [15:0] env;
    logic        busy;
    logic [3:0]  note_idx;
    logic        done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    tone_sequencer dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_fcw(tbl_fcw), .tbl_dur(tbl_dur), .tbl_last(tbl_last),
        .start(start), .stop(stop), .loop(loop), .sample_tick(sample_tick),
        .fccw(fccw), .env(env), .busy(busy), .note_idx(note_idx), .done(done)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int fcw, input int dur, input bit last);
        tbl_we = 1'b1; tbl_addr = a[3:0]; tbl_fcw = fcw[29:0]; tbl_dur = dur[19:0]; tbl_last = last;
        cyc(1);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic tick(input int gap);
        sample_tick = 1'b1; cyc(1); sample_tick = 1'b0; cyc(gap - 1);
    endtask

    task automatic drain(input int max_ticks, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_ticks; i++) begin
            if (busy === 1'b0) break;
            tick(3);
        end
        cyc(2);
        if (busy === 1'b0) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        checks++; if (fccw !== 30'd0) begin failures++; $display("FAIL reset_fccw got=%0d exp=0", fccw); end
        checks++; if (env !== 16'h0) begin failures++; $display("FAIL reset_env got=%h exp=0000", env); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", note_idx); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_single_note();
        int base;
        logic [15:0] exp;
        wr(0, 2460658, 1000, 1'b1);
        loop = 1'b0;
        base = done_cnt;
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_t1 got=%b exp=1", busy); end
        cyc(2);
        checks++; if (fccw !== 30'd2460658) begin failures++; $display("FAIL single_fccw_t3 got=%0d exp=2460658", fccw); end
        checks++; if (env !== 16'h0) begin failures++; $display("FAIL single_env_start got=%h exp=0000", env); end
        for (int i = 1; i <= 1000; i++) begin
            tick(5);
            if (i <= 256)      exp = 16'(i * 64);
            else if (i <= 744) exp = 16'h4000;
            else               exp = 16'((1000 - i) * 64);
            checks++; if (env !== exp) begin failures++; $display("FAIL single_env tick=%0d got=%h exp=%h", i, env, exp); end
            if (i == 999) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_999 got=%b exp=1", busy); end
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL single_done_count got=%0d exp=%0d", done_cnt, base + 1); end
        checks++; if (fccw !== 30'd2460658) begin failures++; $display("FAIL single_fccw_hold got=%0d exp=2460658", fccw); end
    endtask

    task automatic test_loop();
        int base, nchg, end_c;
        int exp_f[3] = '{447392, 671088, 223696};
        int exp_i[3] = '{1, 2, 0};
        logic [15:0] prev_env;
        logic [29:0] prev_f;
        bit ok;
        wr(0, 223696, 600, 1'b0);
        wr(1, 447392, 600, 1'b0);
        wr(2, 671088, 600, 1'b1);
        loop = 1'b1;
        base = done_cnt;
        pulse_start();
        cyc(2);
        checks++; if (fccw !== 30'd223696) begin failures++; $display("FAIL loop_fccw0 got=%0d exp=223696", fccw); end
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL loop_idx0 got=%0d exp=0", note_idx); end
        nchg = 0; end_c = -100; prev_env = env; prev_f = fccw;
        for (int c = 0; c < 12000 && nchg < 3; c++) begin
            sample_tick = (c % 5 == 0);
            cyc(1);
            if (prev_env != 16'h0 && env == 16'h0) end_c = c;
            if (fccw !== prev_f) begin
                checks++; if (fccw !== 30'(exp_f[nchg])) begin failures++; $display("FAIL loop_fccw n=%0d got=%0d exp=%0d", nchg, fccw, exp_f[nchg]); end
                checks++; if (note_idx !== 4'(exp_i[nchg])) begin failures++; $display("FAIL loop_idx n=%0d got=%0d exp=%0d", nchg, note_idx, exp_i[nchg]); end
                checks++; if (c - end_c !== 2) begin failures++; $display("FAIL loop_gap n=%0d got=%0d exp=2", nchg, c - end_c); end
                nchg++;
            end
            prev_env = env; prev_f = fccw;
        end
        sample_tick = 1'b0;
        checks++; if (nchg !== 3) begin failures++; $display("FAIL loop_changes got=%0d exp=3", nchg); end
        checks++; if (done_cnt !== base) begin failures++; $display("FAIL loop_no_done got=%0d exp=%0d", done_cnt, base); end
        loop = 1'b0;
        stop = 1'b1; cyc(1); stop = 1'b0;
        drain(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_stop_idle got=busy exp=idle"); end
        checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL loop_stop_done got=%0d exp=%0d", done_cnt, base + 1); end
    endtask

    task automatic test_short_note();
        int base;
        logic [15:0] peak;
        wr(0, 1111111, 300, 1'b1);
        base = done_cnt;
        pulse_start();
        cyc(2);
        peak = 16'h0;
        for (int i = 1; i <= 300; i++) begin
            tick(5);
            if (env > peak) peak = env;
            if (i == 44) begin
                checks++; if (env !== 16'h0B00) begin failures++; $display("FAIL short_env44 got=%h exp=0b00", env); end
            end
            if (i == 45) begin
                checks++; if (env !== 16'h0AC0) begin failures++; $display("FAIL short_env45 got=%h exp=0ac0", env); end
            end
            if (i == 88) begin
                checks++; if (env !== 16'h0) begin failures++; $display("FAIL short_env88 got=%h exp=0000", env); end
            end
            if (i == 299) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL short_busy299 got=%b exp=1", busy); end
            end
        end
        checks++; if (peak !== 16'h0B00) begin failures++; $display("FAIL short_peak got=%h exp=0b00", peak); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy_end got=%b exp=0", busy); end
        checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL short_done got=%0d exp=%0d", done_cnt, base + 1); end
    endtask

    task automatic test_stop_restart();
        int base;
        bit ok;
        wr(0, 1234567, 2000, 1'b1);
        base = done_cnt;
        pulse_start();
        cyc(2);
        for (int i = 1; i <= 500; i++) tick(5);
        checks++; if (env !== 16'h4000) begin failures++; $display("FAIL stop_env500 got=%h exp=4000", env); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stop_busy_after got=%b exp=1", busy); end
        for (int i = 501; i <= 756; i++) begin
            tick(5);
            if (i == 501) begin
                checks++; if (env !== 16'h3FC0) begin failures++; $display("FAIL stop_env501 got=%h exp=3fc0", env); end
            end
            if (i == 755) begin
                checks++; if (env !== 16'h0040 || busy !== 1'b1) begin failures++; $display("FAIL stop_env755 got=%h/%b exp=0040/1", env, busy); end
            end
        end
        checks++; if (env !== 16'h0) begin failures++; $display("FAIL stop_env756 got=%h exp=0000", env); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy756 got=%b exp=0", busy); end
        checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL stop_done got=%0d exp=%0d", done_cnt, base + 1); end
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
        cyc(2);
        checks++; if (note_idx !== 4'd0 || fccw !== 30'd1234567) begin failures++; $display("FAIL restart_load got=%0d/%0d exp=0/1234567", note_idx, fccw); end
        tick(5);
        checks++; if (env !== 16'h0040) begin failures++; $display("FAIL restart_env1 got=%h exp=0040", env); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        drain(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL restart_stop_idle got=busy exp=idle"); end
    endtask

    task automatic test_skip();
        int base, idx_chg, fchg;
        bit saw_b;
        logic [29:0] prev_f, first_f;
        logic [3:0]  prev_i;
        wr(0, 100000, 40, 1'b0);
        wr(1, 200000, 0, 1'b0);
        wr(2, 300000, 40, 1'b1);
        base = done_cnt;
        pulse_start();
        cyc(2);
        checks++; if (fccw !== 30'd100000 || note_idx !== 4'd0) begin failures++; $display("FAIL skip_first got=%0d/%0d exp=100000/0", fccw, note_idx); end
        saw_b = 1'b0; idx_chg = 0; fchg = 0; first_f = '0;
        prev_f = fccw; prev_i = note_idx;
        for (int c = 0; c < 2000 && busy === 1'b1; c++) begin
            sample_tick = (c % 3 == 0);
            cyc(1);
            if (fccw === 30'd200000) saw_b = 1'b1;
            if (fccw !== prev_f) begin
                if (fchg == 0) first_f = fccw;
                fchg++;
            end
            if (note_idx !== prev_i) idx_chg++;
            prev_f = fccw; prev_i = note_idx;
        end
        sample_tick = 1'b0;
        cyc(2);
        checks++; if (saw_b !== 1'b0) begin failures++; $display("FAIL skip_entry1_played got=1 exp=0"); end
        checks++; if (first_f !== 30'd300000 || fchg !== 1) begin failures++; $display("FAIL skip_fccw got=%0d x%0d exp=300000 x1", first_f, fchg); end
        checks++; if (note_idx !== 4'd2 || idx_chg !== 1) begin failures++; $display("FAIL skip_idx got=%0d x%0d exp=2 x1", note_idx, idx_chg); end
        checks++; if (busy !== 1'b0 || done_cnt !== base + 1) begin failures++; $display("FAIL skip_done got=%b/%0d exp=0/%0d", busy, done_cnt, base + 1); end
    endtask

    task automatic test_async_reset();
        wr(0, 555555, 1000, 1'b1);
        pulse_start();
        cyc(2);
        for (int i = 0; i < 10; i++) tick(5);
        checks++; if (env !== 16'h0280 || busy !== 1'b1) begin failures++; $display("FAIL areset_pre got=%h/%b exp=0280/1", env, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (fccw !== 30'd0) begin failures++; $display("FAIL areset_fccw got=%0d exp=0", fccw); end
        checks++; if (env !== 16'h0) begin failures++; $display("FAIL areset_env got=%h exp=0000", env); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || note_idx !== 4'd0) begin failures++; $display("FAIL areset_ctl got=%b/%b/%0d exp=0/0/0", busy, done, note_idx); end
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_start_stop_same();
        int base;
        base = done_cnt;
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", busy); end
        cyc(4);
        checks++; if (busy !== 1'b0 || fccw !== 30'd0 || done_cnt !== base) begin failures++; $display("FAIL startstop_idle got=%b/%0d/%0d exp=0/0/%0d", busy, fccw, done_cnt, base); end
    endtask

    initial begin
        reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_fcw = '0; tbl_dur = '0; tbl_last = 1'b0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; sample_tick = 1'b0;
        test_reset();
        test_single_note();
        test_loop();
        test_short_note();
        test_stop_restart();
        test_skip();
        test_async_reset();
        test_start_stop_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
